dac_sample_streamer: RTL and testbench
======================================

Name: dac_sample_streamer

Overview:
Upstream feeder for the SPI_MCP4822 DAC driver. Buffers 12-bit samples from a producer (ADC path or DSP stage) in a small FIFO. At a fixed sample rate derived from the 125 MHz system clock, it issues one Tx pulse plus data to the DAC driver, then waits for the driver's CC (conversion complete) flag before the next transfer. Flags FIFO underflow and late (missed-deadline) samples.

Parameters:
DATA_W, 12, sample width; matches DAC driver i_DATA.
DEPTH, 16, FIFO entries; power of 2, at least 2.
SAMPLE_DIV, 2500, clk cycles per sample tick (2500 gives 50 kS/s at 125 MHz); at least 2.
RESET_CODE, 12'h800, value on o_dac_data after reset (midscale).

Ports:
clk  in  1  system clock, 125 MHz.
rst_n  in  1  asynchronous active-low reset.
i_data  in  DATA_W  sample from producer.
i_valid  in  1  producer sample valid.
o_ready  out  1  FIFO can accept; a push occurs when i_valid && o_ready.
o_tx  out  1  one-cycle pulse to DAC driver Tx.
o_dac_data  out  DATA_W  to DAC driver i_DATA; held stable from o_tx until CC is seen.
i_cc  in  1  DAC driver CC flag; the rising edge marks transfer done.
i_clr_flags  in  1  synchronous clear of the sticky flags.
o_underflow  out  1  sticky: a tick found the FIFO empty.
o_late  out  1  sticky: a tick arrived while a transfer was still in flight.
o_level  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): FIFO empty, o_level=0, o_ready=1, o_tx=0, o_dac_data=RESET_CODE, flags=0, divider=0, pending=0, state IDLE, cc_q=0.
- Divider counts 0..SAMPLE_DIV-1 and wraps. tick=1 for the single cycle when count==SAMPLE_DIV-1. The first tick occurs SAMPLE_DIV cycles after reset release.
- CC edge: cc_q registers i_cc. cc_rise = i_cc && !cc_q.
- FIFO: circular buffer with pointer wrap at DEPTH. o_ready = (o_level != DEPTH), registered from the level.
  - Push when i_valid && o_ready.
  - Pop only from the FSM ISSUE action.
  - Simultaneous push and pop: level unchanged, data order preserved.
  - Push while empty, same cycle as an ISSUE: the pop sees empty (underflow) and the pushed word stays for the next tick. There is no fall-through.
- FSM:
  - IDLE: on tick or pending → ISSUE; clear pending.
  - ISSUE (1 cycle): if level>0, pop the head into o_dac_data. If empty, keep the previous o_dac_data (repeat last sample) and set o_underflow. Assert o_tx=1 this cycle (registered, so visible the cycle after entry) → WAIT_CC.
  - WAIT_CC: on cc_rise → IDLE. A tick in WAIT_CC sets o_late and pending=1; only one pending tick is remembered, so further ticks are dropped but still set o_late.
  - tick and cc_rise in the same WAIT_CC cycle: set o_late and pending, and go to IDLE. The next cycle goes to ISSUE.
- o_dac_data changes only in the ISSUE cycle. o_tx is never high on two consecutive cycles.
- Latency: tick in IDLE → o_tx high 2 cycles later (IDLE→ISSUE registered, o_tx registered).
- Sticky flags: clear on i_clr_flags. A set event in the same cycle as i_clr_flags wins, so the flag stays 1.
- Reset mid-transfer: the FSM returns to IDLE and o_tx drops immediately. The DAC driver is not aborted; a stale CC after reset is ignored because cc_q resets to 0 and the FSM is in IDLE.

Test Plan:
- Reset, SAMPLE_DIV=100, push 12'hFD8 then 12'h123, CC pulse 40 cycles after each o_tx → o_tx at cycles ~102 and ~202, o_dac_data=FD8 then 123, flags 0, o_level back to 0.
- Fill 16 samples with no ticks → o_level=16, o_ready=0; a 17th i_valid is not accepted; data drains in push order over 16 ticks.
- Empty FIFO at tick → o_tx still pulses, o_dac_data repeats the last value (RESET_CODE 800 if nothing has been sent yet), o_underflow=1 and stays set until i_clr_flags.
- Hold i_cc low for 250 cycles (SAMPLE_DIV=100) → o_late=1, exactly one extra o_tx issued right after the CC rise, the second missed tick dropped.
- Assert rst_n low asynchronously in WAIT_CC → o_tx=0, o_dac_data=800, o_level=0, o_ready=1 without waiting for a clock edge.
- Push and ISSUE-pop in the same cycle with level=3 → level stays 3, popped word is the head, pushed word is at the tail.

Source files
------------

// File: rtl/dac_sample_streamer.sv
// Sample FIFO and pacing engine that feeds the MCP4822 SPI driver: one Tx per
// sample tick, then wait for the driver's CC rising edge before the next transfer.
module dac_sample_streamer #(
    parameter int                 DATA_W     = 12,
    parameter int                 DEPTH      = 16,
    parameter int                 SAMPLE_DIV = 2500,
    parameter logic [DATA_W-1:0]  RESET_CODE = 12'h800
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_tx,
    output logic [DATA_W-1:0]           o_dac_data,
    input  logic                        i_cc,
    input  logic                        i_clr_flags,
    output logic                        o_underflow,
    output logic                        o_late,
    output logic [$clog2(DEPTH):0]      o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_CC
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 pending;
    logic                 pending_next;
    logic                 issue;
    logic                 set_late;
    logic                 set_underflow;

    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 cc_q;
    logic                 cc_rise;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_next;
    logic                 do_push;
    logic                 do_pop;

    assign tick    = (div_cnt == DIV_LAST);
    assign cc_rise = i_cc && !cc_q;
    assign do_push = i_valid && o_ready;
    // An ISSUE against an empty FIFO never pops, so a same-cycle push waits for the next tick.
    assign do_pop  = issue && (o_level != '0);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch can be inferred.
        state_next    = state;
        pending_next  = pending;
        issue         = 1'b0;
        set_late      = 1'b0;
        set_underflow = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick || pending) begin
                    state_next   = S_ISSUE;
                    pending_next = 1'b0;
                end
            end
            S_ISSUE: begin
                issue         = 1'b1;
                set_underflow = (o_level == '0);
                state_next    = S_WAIT_CC;
                if (tick) begin
                    set_late     = 1'b1;
                    pending_next = 1'b1;
                end
            end
            S_WAIT_CC: begin
                // Only one missed tick is remembered; later ones only raise the flag.
                if (tick) begin
                    set_late     = 1'b1;
                    pending_next = 1'b1;
                end
                if (cc_rise) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        level_next = o_level;
        case ({do_push, do_pop})
            2'b10:   level_next = o_level + 1'b1;
            2'b01:   level_next = o_level - 1'b1;
            default: level_next = o_level;
        endcase
    end

    // NOTE: sample storage is deliberately left out of reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            div_cnt     <= '0;
            cc_q        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_level     <= '0;
            o_ready     <= 1'b1;
            o_tx        <= 1'b0;
            o_dac_data  <= RESET_CODE;
            o_underflow <= 1'b0;
            o_late      <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            cc_q    <= i_cc;

            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                o_dac_data <= mem[rd_ptr];
            end
            o_level <= level_next;
            o_ready <= (level_next != LVL_FULL);

            o_tx <= issue;

            // A set event in the same cycle as a clear keeps the flag high.
            o_underflow <= set_underflow || (o_underflow && !i_clr_flags);
            o_late      <= set_late      || (o_late      && !i_clr_flags);
        end
    end

    a_tx_single : assert property (@(posedge clk) disable iff (!rst_n) o_tx |=> !o_tx);
    a_level_max : assert property (@(posedge clk) disable iff (!rst_n) o_level <= LVL_FULL);

endmodule

// File: tb/tb_dac_sample_streamer.sv
// Directed bench for dac_sample_streamer: a queue scoreboard predicts every
// sample the DAC should see, checked at each observed Tx pulse.
module tb_dac_sample_streamer;

    localparam int                DATA_W     = 12;
    localparam int                DEPTH      = 16;
    localparam int                SAMPLE_DIV = 100;
    localparam logic [DATA_W-1:0] RESET_CODE = 12'h800;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_tx;
    logic [DATA_W-1:0] o_dac_data;
    logic              i_cc;
    logic              i_clr_flags;
    logic              o_underflow;
    logic              o_late;
    logic [4:0]        o_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_cyc = 0;
    int prev_tx_cyc = 0;
    int rel_cyc = 0;
    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] last_sent;

    dac_sample_streamer #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .RESET_CODE (RESET_CODE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_tx        (o_tx),
        .o_dac_data  (o_dac_data),
        .i_cc        (i_cc),
        .i_clr_flags (i_clr_flags),
        .o_underflow (o_underflow),
        .o_late      (o_late),
        .o_level     (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        chk("ready_before_push", 32'(o_ready), 32'(model_q.size() != DEPTH));
        i_valid = 1'b1;
        i_data  = d;
        step();
        i_valid = 1'b0;
        model_q.push_back(d);
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int n;
        logic [DATA_W-1:0] exp_d;
        n = 0;
        while (!o_tx && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_tx_seen"}, 32'(o_tx), 32'd1);
        if (o_tx) begin
            if (model_q.size() > 0) exp_d = model_q.pop_front();
            else                    exp_d = last_sent;
            last_sent = exp_d;
            chk({tag, "_data"}, 32'(o_dac_data), 32'(exp_d));
            prev_tx_cyc = tx_cyc;
            tx_cyc      = cyc;
        end
    endtask

    task automatic do_transfer(input string tag, input int budget, input int cc_delay);
        wait_tx(tag, budget);
        step();
        chk({tag, "_tx_single"}, 32'(o_tx), 32'd0);
        repeat (cc_delay - 2) step();
        i_cc = 1'b1;
        step();
        step();
        i_cc = 1'b0;
    endtask

    initial begin
        int n_tx;
        rst_n       = 1'b0;
        i_data      = '0;
        i_valid     = 1'b0;
        i_cc        = 1'b0;
        i_clr_flags = 1'b0;
        last_sent   = RESET_CODE;

        // Reset state
        #22;
        chk("rst_tx",        32'(o_tx),        32'd0);
        chk("rst_dac",       32'(o_dac_data),  32'(RESET_CODE));
        chk("rst_level",     32'(o_level),     32'd0);
        chk("rst_ready",     32'(o_ready),     32'd1);
        chk("rst_underflow", 32'(o_underflow), 32'd0);
        chk("rst_late",      32'(o_late),      32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        step();

        // Basic two-sample stream
        push(12'hFD8);
        push(12'h123);
        chk("basic_level2", 32'(o_level), 32'd2);
        do_transfer("basic_first", 3 * SAMPLE_DIV, 40);
        chk("basic_first_latency",
            32'((tx_cyc - rel_cyc >= SAMPLE_DIV) && (tx_cyc - rel_cyc <= SAMPLE_DIV + 2)), 32'd1);
        do_transfer("basic_second", 3 * SAMPLE_DIV, 40);
        chk("basic_period",    32'(tx_cyc - prev_tx_cyc), 32'(SAMPLE_DIV));
        chk("basic_level0",    32'(o_level),     32'd0);
        chk("basic_underflow", 32'(o_underflow), 32'd0);
        chk("basic_late",      32'(o_late),      32'd0);

        // Fill to full, reject an extra word, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            push(DATA_W'((i + 1) * 12'h0A5) ^ DATA_W'(i));
        end
        chk("full_level", 32'(o_level), 32'(DEPTH));
        chk("full_ready", 32'(o_ready), 32'd0);
        i_valid = 1'b1;
        i_data  = 12'hBAD;
        step();
        i_valid = 1'b0;
        chk("full_reject_level", 32'(o_level), 32'(DEPTH));
        chk("full_reject_ready", 32'(o_ready), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            do_transfer("drain", 3 * SAMPLE_DIV, 40);
        end
        chk("drain_level0", 32'(o_level), 32'd0);
        chk("drain_ready",  32'(o_ready), 32'd1);

        // Underflow repeats the last sample and stays sticky until cleared
        chk("uf_before", 32'(o_underflow), 32'd0);
        do_transfer("uf_repeat", 3 * SAMPLE_DIV, 40);
        chk("uf_set", 32'(o_underflow), 32'd1);
        repeat (20) step();
        chk("uf_sticky", 32'(o_underflow), 32'd1);
        i_clr_flags = 1'b1;
        step();
        i_clr_flags = 1'b0;
        chk("uf_cleared", 32'(o_underflow), 32'd0);

        // Late CC: two ticks missed, exactly one catch-up transfer
        chk("late_before", 32'(o_late), 32'd0);
        push(12'h3A1);
        push(12'h4B2);
        push(12'h5C3);
        do_transfer("late_a", 3 * SAMPLE_DIV, 250);
        chk("late_set", 32'(o_late), 32'd1);
        do_transfer("late_b_catchup", 4, 10);
        do_transfer("late_c_regular", 3 * SAMPLE_DIV, 10);
        chk("late_dropped_tick", 32'(tx_cyc - prev_tx_cyc > 20), 32'd1);
        chk("late_no_underflow", 32'(o_underflow), 32'd0);
        i_clr_flags = 1'b1;
        step();
        i_clr_flags = 1'b0;
        chk("late_cleared", 32'(o_late), 32'd0);

        // Push in the same cycle as an ISSUE pop with three words queued
        push(12'h611);
        push(12'h722);
        push(12'h833);
        chk("pp_level3", 32'(o_level), 32'd3);
        while (cyc < tx_cyc + SAMPLE_DIV - 1) step();
        chk("pp_level3_at_issue", 32'(o_level), 32'd3);
        push(12'h944);
        chk("pp_level_kept", 32'(o_level), 32'd3);
        do_transfer("pp_head", 1, 10);
        chk("pp_period", 32'(tx_cyc - prev_tx_cyc), 32'(SAMPLE_DIV));
        do_transfer("pp_drain", 3 * SAMPLE_DIV, 10);
        do_transfer("pp_drain", 3 * SAMPLE_DIV, 10);
        do_transfer("pp_tail",  3 * SAMPLE_DIV, 10);
        chk("pp_level0", 32'(o_level), 32'd0);

        // Asynchronous reset while a transfer is in flight
        push(12'hA55);
        push(12'hB66);
        wait_tx("arst_tx", 3 * SAMPLE_DIV);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_low", 32'(o_tx),       32'd0);
        chk("arst_dac",    32'(o_dac_data), 32'(RESET_CODE));
        chk("arst_level",  32'(o_level),    32'd0);
        chk("arst_ready",  32'(o_ready),    32'd1);
        model_q.delete();
        last_sent = RESET_CODE;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        i_cc = 1'b1;
        step();
        step();
        i_cc = 1'b0;
        n_tx = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_tx) n_tx++;
        end
        chk("arst_stale_cc_ignored", 32'(n_tx), 32'd0);
        chk("arst_underflow_clear", 32'(o_underflow), 32'd0);
        do_transfer("arst_reset_code_repeat", 3 * SAMPLE_DIV, 10);
        chk("arst_underflow_set", 32'(o_underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
